adc_buf_ctrl: RTL
=================

ADC_BUF_CTRL -- requirements
Module: adc_buf_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, sample buffer address width (4096 entries).
REQ-002 Parameter DATA_W, default 8, sample and UART byte width.
REQ-003 clk  input  1  single system clock; the buffer RAM write and read ports both run on it.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a capture; ignored unless in IDLE.
REQ-006 abort  input  1  one-cycle request to cancel any capture/drain and return to IDLE.
REQ-007 cap_len  input  ADDR_W+1  number of samples to capture; sampled on accepted start.
REQ-008 adc_valid  input  1  ADC sample strobe.
REQ-009 adc_data  input  DATA_W  ADC sample, qualified by adc_valid.
REQ-010 ram_cea, ram_ada[ADDR_W], ram_din[DATA_W]  output  buffer write port: enable, address, data.
REQ-011 ram_ceb, ram_adb[ADDR_W]  output  buffer read port: enable, address.
REQ-012 ram_oce, ram_reset  output  1 each  tied 1 and 0 respectively.
REQ-013 ram_dout  input  DATA_W  buffer read data, valid the cycle after ram_ceb.
REQ-014 tx_data  output  DATA_W  byte to UART transmitter.
REQ-015 tx_valid / tx_ready  output / input  1 each  valid/ready handshake to UART.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 done  output  1  one-cycle pulse when the final byte is accepted by the UART.

Function
REQ-018 States SHALL be IDLE, CAPTURE, RD_REQ, RD_WAIT, TX_HOLD.
REQ-019 IDLE->CAPTURE on start; len register = min(cap_len, 4096); wr_ptr=0, rd_ptr=0.
REQ-020 start with cap_len=0 SHALL stay in IDLE and pulse done in the following cycle.
REQ-021 CAPTURE: each adc_valid cycle SHALL drive ram_cea=1, ram_ada=wr_ptr, ram_din=adc_data (combinational from inputs), then wr_ptr+1.
REQ-022 CAPTURE->RD_REQ in the cycle after the write at wr_ptr=len-1; adc_valid thereafter ignored.
REQ-023 RD_REQ: ram_ceb=1, ram_adb=rd_ptr for exactly one cycle, ->RD_WAIT.
REQ-024 RD_WAIT: register ram_dout into tx_data, ->TX_HOLD with tx_valid=1 next cycle.
REQ-025 TX_HOLD: tx_valid and tx_data SHALL stay stable until tx_ready=1; on transfer rd_ptr+1.
REQ-026 On transfer with rd_ptr=len-1: tx_valid=0, done pulse, ->IDLE; else ->RD_REQ.
REQ-027 Byte order out SHALL equal capture order; len=4096 SHALL wrap pointers without aliasing (counters ADDR_W+1 bits wide).
REQ-028 abort in any state SHALL take priority over all other transitions: ->IDLE next cycle, tx_valid=0, no done pulse; RAM contents untouched.
REQ-029 start and abort in the same IDLE cycle: abort wins, stay IDLE.
REQ-030 ram_cea and ram_ceb SHALL never be asserted outside CAPTURE and RD_REQ respectively.

Reset
REQ-031 rst_n=0 at a clk edge SHALL force IDLE, pointers and len 0, tx_data 0, tx_valid/busy/done/ram_cea/ram_ceb 0, ram_ada/ram_adb/ram_din 0, regardless of current state.
REQ-032 Reset mid-capture or mid-drain SHALL abandon the operation without done; RAM is not cleared.

Structure
REQ-033 State encoding enum and default ADDR_W/DATA_W constants SHALL live in shared package adc_pkg.
REQ-034 No sub-modules; the RAM instance is external, connected by the integrator.

Verification
REQ-035 cap_len=4, adc_valid every 3rd cycle, data 0x11,0x22,0x33,0x44, tx_ready=1 -> four writes at addr 0..3, tx bytes 0x11..0x44 in order, one done pulse.
REQ-036 cap_len=4096, ramp data, tx_ready random 30% -> 4096 bytes equal to ramp mod 256, no byte dropped or repeated, tx_data stable while tx_valid && !tx_ready.
REQ-037 cap_len=5000 -> exactly 4096 writes and 4096 bytes out.
REQ-038 cap_len=0 -> no RAM enables, done pulse one cycle after start, busy never high.
REQ-039 abort during CAPTURE at sample 2, then during TX_HOLD -> IDLE next cycle, tx_valid 0, no done; subsequent start (cap_len=2) completes normally.
REQ-040 rst_n=0 for one cycle in RD_WAIT -> all outputs at reset values next cycle; start while busy ignored.

Source files
------------

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants and state encoding for the ADC capture buffer
package adc_pkg;

    localparam int ADC_ADDR_W = 12;
    localparam int ADC_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_TX_HOLD = 3'd4
    } adc_state_t;

endpackage

// File: rtl/adc_buf_ctrl.sv
// rtl/adc_buf_ctrl.sv - capture ADC samples into an external RAM, then drain them to a UART in order
module adc_buf_ctrl
    import adc_pkg::*;
#(
    parameter int ADDR_W = ADC_ADDR_W,
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   cap_len,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_ada,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_ceb,
    output logic [ADDR_W-1:0] ram_adb,
    output logic              ram_oce,
    output logic              ram_reset,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    // Pointers and length are one bit wider than the address so a full buffer does not alias to zero.
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    adc_state_t        state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              done_q, done_d;
    logic              wr_en;
    logic              rd_en;

    assign wr_en = (state_q == ST_CAPTURE) && adc_valid;
    assign rd_en = (state_q == ST_RD_REQ);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
        if (abort) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cap_len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d  = ST_CAPTURE;
                            len_d    = (cap_len > DEPTH) ? DEPTH : cap_len;
                            wr_ptr_d = '0;
                            rd_ptr_d = '0;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid) begin
                        wr_ptr_d = wr_ptr_q + ONE;
                        if (wr_ptr_q == len_q - ONE) begin
                            state_d = ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    tx_data_d  = ram_dout;
                    tx_valid_d = 1'b1;
                    state_d    = ST_TX_HOLD;
                end
                ST_TX_HOLD: begin
                    if (tx_ready) begin
                        rd_ptr_d   = rd_ptr_q + ONE;
                        tx_valid_d = 1'b0;
                        if (rd_ptr_q == len_q - ONE) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RD_REQ;
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end

    // Write port follows the ADC strobe directly so no sample is delayed or lost.
    assign ram_cea   = wr_en;
    assign ram_ada   = wr_en ? wr_ptr_q[ADDR_W-1:0] : '0;
    assign ram_din   = wr_en ? adc_data : '0;
    assign ram_ceb   = rd_en;
    assign ram_adb   = rd_en ? rd_ptr_q[ADDR_W-1:0] : '0;
    assign ram_oce   = 1'b1;
    assign ram_reset = 1'b0;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule
